calc_sequencer: RTL

- Sequences the row multiplier for one full classification pass.
- On a start request from the Avalon interface, it issues one multiply per output row, waits for each row to complete, and writes each row result into the result/output register file.
- Tracks the arg-max row (the classified digit) during the pass and signals completion back to the Avalon interface with done_calc.
- Sits between avalon_interface (start_calc, done_calc) and the multiplier (begin_mult, row_select, done_row, row_result).

---
 rtl/calc_sequencer_if.sv | 31 +++
 rtl/calc_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/calc_sequencer_if.sv
// Handshake bundle between the calc sequencer, the Avalon front end, the row
// multiplier and the result register file.
interface calc_sequencer_if #(
    parameter int ROW_W    = 4,
    parameter int RESULT_W = 16
);
    logic                       start_calc;
    logic                       done_row;
    logic signed [RESULT_W-1:0] row_result;
    logic                       begin_mult;
    logic [ROW_W-1:0]           row_select;
    logic                       res_wen;
    logic [ROW_W-1:0]           res_addr;
    logic signed [RESULT_W-1:0] res_data;
    logic                       done_calc;
    logic                       busy;
    logic [ROW_W-1:0]           result_class;
    logic                       timeout_err;

    modport master (
        input  start_calc, done_row, row_result,
        output begin_mult, row_select, res_wen, res_addr, res_data,
               done_calc, busy, result_class, timeout_err
    );

    modport slave (
        output start_calc, done_row, row_result,
        input  begin_mult, row_select, res_wen, res_addr, res_data,
               done_calc, busy, result_class, timeout_err
    );
endinterface

// File: rtl/calc_sequencer.sv
// Walks the row multiplier over every output row, stores each row result and
// tracks the signed arg-max row as the classified digit.
module calc_sequencer #(
    parameter int NUM_ROWS = 10,
    parameter int ROW_W    = 4,
    parameter int RESULT_W = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             n_rst,
    calc_sequencer_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, FINISH} state_t;

    state_t                     state_q, state_d;
    logic                       start_q;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [WD_W-1:0]            wdog_q, wdog_d;
    logic signed [RESULT_W-1:0] max_q, max_d;
    logic                       maxv_q, maxv_d;
    logic [ROW_W-1:0]           cand_q, cand_d;
    logic                       bm_q, bm_d, wen_q, wen_d, done_q, done_d, busy_q, busy_d;
    logic [ROW_W-1:0]           addr_q, addr_d, class_q, class_d;
    logic signed [RESULT_W-1:0] data_q, data_d;
    logic                       terr_q, terr_d;
    logic                       start_edge, last_row;

    assign start_edge = bus.start_calc & ~start_q;
    assign last_row   = (row_q == ROW_W'(NUM_ROWS - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wdog_d  = wdog_q;
        max_d   = max_q;
        maxv_d  = maxv_q;
        cand_d  = cand_q;
        addr_d  = addr_q;
        data_d  = data_q;
        class_d = class_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    row_d   = '0;
                    terr_d  = 1'b0;
                    maxv_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A row completing on the watchdog's last cycle is still kept.
                if (bus.done_row) begin
                    addr_d = row_q;
                    data_d = bus.row_result;
                    if (!maxv_q || bus.row_result > max_q) begin
                        max_d  = bus.row_result;
                        cand_d = row_q;
                        maxv_d = 1'b1;
                    end
                    state_d = STORE;
                end else if (wdog_q == WD_W'(TIMEOUT)) begin
                    terr_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            STORE: begin
                if (last_row) begin
                    class_d = cand_q;
                    state_d = FINISH;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with it.
    assign bm_d   = (state_d == ISSUE);
    assign wen_d  = (state_d == STORE);
    assign done_d = (state_d == FINISH);
    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            row_q   <= '0;
            wdog_q  <= '0;
            max_q   <= '0;
            maxv_q  <= 1'b0;
            cand_q  <= '0;
            bm_q    <= 1'b0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            class_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start_calc;
            row_q   <= row_d;
            wdog_q  <= wdog_d;
            max_q   <= max_d;
            maxv_q  <= maxv_d;
            cand_q  <= cand_d;
            bm_q    <= bm_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            class_q <= class_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.begin_mult   = bm_q;
    assign bus.row_select   = row_q;
    assign bus.res_wen      = wen_q;
    assign bus.res_addr     = addr_q;
    assign bus.res_data     = data_q;
    assign bus.done_calc    = done_q;
    assign bus.busy         = busy_q;
    assign bus.result_class = class_q;
    assign bus.timeout_err  = terr_q;
endmodule
